// File: rtl/sat_enum_driver_if.sv
// Bundles the host handshake and the circuit-under-evaluation signals of sat_enum_driver.
// Latency: none, this is wiring only.
// Backpressure: none. One candidate per cycle, and the circuit side has no stall.
interface sat_enum_driver_if #(
    parameter int N_VARS = 7
);
    // Host side
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              found;
    logic [N_VARS-1:0] model;
    logic [N_VARS:0]   evals;
    // Circuit side
    logic [N_VARS-1:0] assign_o;
    logic              assign_vld_o;
    logic              sat_i;

    // Driver view
    modport master (
        input  start, abort, sat_i,
        output assign_o, assign_vld_o, busy, done, found, model, evals
    );

    // Host and circuit view
    modport slave (
        output start, abort, sat_i,
        input  assign_o, assign_vld_o, busy, done, found, model, evals
    );
endinterface

// File: rtl/sat_enum_driver.sv
// Exhaustively enumerates N_VARS-bit assignments into a SAT circuit and stops at the first hit.
// Latency: candidate i is issued i cycles after start; its sat_i is sampled LAT+1 edges later.
// Backpressure: none. start is ignored while busy, and abort always wins.
module sat_enum_driver #(
    parameter int N_VARS = 7,
    parameter int LAT    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sat_enum_driver_if.master bus
);
    // Depth of the result-alignment line. Kept at least 1 so the arrays stay
    // legal when LAT=0; in that case the line is bypassed.
    localparam int PD = (LAT == 0) ? 1 : LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_VARS-1:0] cnt_q, cnt_d;
    logic              found_q, found_d;
    logic [N_VARS-1:0] model_q, model_d;
    logic [N_VARS:0]   evals_q, evals_d;
    logic [PD-1:0]     vld_pipe_q, vld_pipe_d;
    logic [N_VARS-1:0] asg_pipe_q [PD];
    logic [N_VARS-1:0] asg_pipe_d [PD];

    logic              issue_vld;
    logic [N_VARS-1:0] issue_asg;
    logic              smp_vld;
    logic [N_VARS-1:0] smp_asg;
    logic              searching;
    logic              last_issue;
    logic              hit;

    // Candidate presented to the circuit, and the (valid, assignment) pair
    // whose result arrives on sat_i this cycle.
    always_comb begin
        issue_vld  = (state_q == RUN);
        issue_asg  = issue_vld ? cnt_q : '0;
        smp_vld    = (LAT == 0) ? issue_vld : vld_pipe_q[PD-1];
        smp_asg    = (LAT == 0) ? issue_asg : asg_pipe_q[PD-1];
        searching  = (state_q == RUN) || (state_q == DRAIN);
        last_issue = issue_vld && (cnt_q == '1);
        hit        = searching && smp_vld && bus.sat_i;
    end

    // Next-state logic, counters, the result latch, and the alignment-line shift.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        found_d       = found_q;
        model_d       = model_q;
        evals_d       = evals_q;
        vld_pipe_d[0] = issue_vld;
        asg_pipe_d[0] = issue_asg;
        for (int i = 1; i < PD; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            asg_pipe_d[i] = asg_pipe_q[i-1];
        end

        if (bus.abort) begin
            // The model and evals of the interrupted search stay visible.
            state_d    = IDLE;
            found_d    = 1'b0;
            vld_pipe_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        found_d    = 1'b0;
                        model_d    = '0;
                        evals_d    = '0;
                        vld_pipe_d = '0;
                    end
                end
                RUN, DRAIN: begin
                    if (smp_vld) begin
                        evals_d = evals_q + 1'b1;
                    end
                    if (hit) begin
                        // First hit wins: in-flight candidates are dropped.
                        state_d    = DONE;
                        found_d    = 1'b1;
                        model_d    = smp_asg;
                        vld_pipe_d = '0;
                    end else if (state_q == RUN) begin
                        if (last_issue) begin
                            // Counter parks at all-ones. With no alignment line,
                            // the last result has just been sampled.
                            state_d = (LAT == 0) ? DONE : DRAIN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (vld_pipe_d == '0) begin
                        // The final in-flight result was sampled on this edge.
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            model_q    <= '0;
            evals_q    <= '0;
            vld_pipe_q <= '0;
            for (int i = 0; i < PD; i++) begin
                asg_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
            model_q    <= model_d;
            evals_q    <= evals_d;
            vld_pipe_q <= vld_pipe_d;
            for (int i = 0; i < PD; i++) begin
                asg_pipe_q[i] <= asg_pipe_d[i];
            end
        end
    end

    // Output drive. The assignment is forced to zero outside RUN.
    always_comb begin
        bus.assign_o     = issue_asg;
        bus.assign_vld_o = issue_vld;
        bus.busy         = searching;
        bus.done         = (state_q == DONE);
        bus.found        = found_q;
        bus.model        = model_q;
        bus.evals        = evals_q;
    end
endmodule

// File: doc/sat_enum_driver.md
# sat_enum_driver

Exhaustive assignment generator and result collector for the combinational CNF/AIG benchmark circuits (e.g. the multiplier-factorization `sat` cones). It drives every assignment of an N-variable input vector into the circuit under evaluation, samples the circuit's `sat` output through a configurable latency, and stops at the first satisfying assignment or after the full space is exhausted. It sits directly upstream of the benchmark circuit and owns the start/done handshake toward the host controller.

## Interface
- `N_VARS`, default 7: width of the assignment vector. For the 19-factorization benchmark, bits [3:0] map to `a[3:0]` and bits [6:4] map to `b[2:0]`.
- `LAT`, default 0: cycles between `assign_o` and the matching `sat_i`. Use 0 for a purely combinational circuit; the range is 0–8.

Ports (clock and reset first):
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin a search. Ignored while `busy`=1.
- `abort`, in, 1: terminates the search and returns to IDLE.
- `assign_o`, out, N_VARS: candidate assignment presented to the circuit.
- `assign_vld_o`, out, 1: `assign_o` carries a live candidate this cycle.
- `sat_i`, in, 1: circuit result, qualified by the internal delayed valid.
- `busy`, out, 1: search in progress (RUN or DRAIN).
- `done`, out, 1: search finished. Level signal, held until the next accepted `start`.
- `found`, out, 1: the finished search hit a satisfying assignment.
- `model`, out, N_VARS: first satisfying assignment. Valid when `done`&`found`.
- `evals`, out, N_VARS+1: number of assignments whose `sat_i` has been sampled.

## Operation
- States:
  - IDLE: reset state.
  - RUN: issuing candidates.
  - DRAIN: all candidates issued, waiting for in-flight results.
  - DONE: result held.
- IDLE/DONE + `start`: go to RUN. Clear the counter, `evals`, `found`, `model`, `done` and the valid pipe.
- RUN:
  - Each cycle present `assign_o` = counter with `assign_vld_o`=1, then increment the counter.
  - After issuing 2^N_VARS−1 (all ones), go to DRAIN. The counter does not wrap; `assign_vld_o`=0 from then on.
- Result tracking:
  - A LAT-deep shift line carries (valid, assignment) alongside the circuit.
  - At each edge where the delayed valid=1, increment `evals`.
  - If `sat_i`=1 at that edge, latch `model` = delayed assignment, set `found`=1, kill the remaining pipe entries and go to DONE.
  - Only the first hit is kept.
- DRAIN: go to DONE when the pipe holds no valid entry, with `found`=0.
- `abort` in any state: go to IDLE. Clear `busy`, `done`, `found`, `assign_vld_o`. Leave `model`/`evals` unchanged.
- Priority:
  - `abort` > hit > end-of-space.
  - A hit on the same edge as the last issue goes to DONE with `found`=1.
  - `start` and `abort` together: `abort` wins.
- Outputs while not RUN: `assign_o` held at 0, `assign_vld_o`=0.
- Reset (asynchronous, any time, including mid-search): all outputs 0, state IDLE, pipe cleared.

## Timing
- `start` sampled at edge k. `assign_o`=i is presented in the cycle after edge k+i.
- `sat_i` for candidate i is sampled at edge k+i+1+LAT. On a hit, `done`/`found`/`model` are visible after that edge.
- Exhaustive miss: `done`=1 after edge k+2^N_VARS+LAT, with `evals`=2^N_VARS.
- `busy`=1 from after edge k until the edge that asserts `done` or the edge that takes `abort`.
- One candidate per cycle. No stall input.

## Test plan
- N_VARS=7, LAT=0, the real 19-factorization circuit attached, `start` at edge 0:
  - All 128 candidates issued.
  - `done`=1 after edge 128 with `found`=0 and `evals`=128. 19 is prime, so the result is UNSAT.
- N_VARS=7, LAT=0, behavioural circuit `sat_i`=(assign==7'h2A), `start` at edge 0:
  - `done`=`found`=1 after edge 43, `model`=7'h2A, `evals`=43.
  - `assign_vld_o`=0 afterwards.
- Same circuit with LAT=3 (registered model), `start` at edge 0:
  - Hit sampled at edge 46, `model`=7'h2A, `evals`=43.
  - Issued candidates past 0x2A are discarded.
- Circuit with `sat_i`=1 only for 7'h7F, LAT=2:
  - The hit arrives during DRAIN. `done` after edge 130, `found`=1, `model`=7'h7F, `evals`=128.
- Mid-search interruptions:
  - `abort` at edge 20: IDLE, `busy`=0, `done`=0.
  - `start` at edge 20 while busy is ignored.
  - `rst_n` low mid-search: all outputs 0 immediately.
  - A following `start` restarts from candidate 0.
- Back-to-back: `start` while in DONE clears `done`/`found` on that edge and reruns with identical results.
